// File: rtl/sysarr_pkg.sv
// Shared types and constants for the systolic-array operand feeder.
package sysarr_pkg;

  localparam int unsigned DefaultBitsAb = 8;
  localparam int unsigned DefaultDim    = 8;

  typedef logic signed [DefaultBitsAb-1:0] operand_t;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  // Beats needed to push one full tile through the skew window.
  function automatic int unsigned tile_beats(input int unsigned dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/skew_bank.sv
// One DIM x DIM operand bank: row-wide write port and a combinational skewed read port.
module skew_bank
  import sysarr_pkg::*;
#(
  parameter int unsigned BITS_AB = DefaultBitsAb,
  parameter int unsigned DIM     = DefaultDim,
  parameter int unsigned CNT_W   = $clog2(2 * DIM)
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DIM)-1:0]         wr_row,
  input  logic [DIM-1:0][BITS_AB-1:0]    wr_data,
  input  logic [CNT_W-1:0]               t,
  input  logic                           t_mode,
  output logic [DIM-1:0][BITS_AB-1:0]    rd_data
);

  localparam int unsigned RowW = $clog2(DIM);

  // Contents survive reset on purpose: unwritten rows stream stale data.
  logic [DIM-1:0][BITS_AB-1:0] mem_q [DIM];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    logic [CNT_W:0]  k;
    logic [RowW-1:0] ki;

    // k = t - j; a negative result wraps high and falls outside the window.
    assign k  = {1'b0, t} - (CNT_W + 1)'(j);
    assign ki = k[RowW-1:0];

    assign rd_data[j] = (k < (CNT_W + 1)'(DIM)) ?
                        (t_mode ? mem_q[ki][j] : mem_q[j][ki]) : '0;
  end

endmodule

// File: rtl/skew_pingpong_buf.sv
// Ping-pong tile buffer feeding the systolic array with diagonally skewed lanes.
module skew_pingpong_buf
  import sysarr_pkg::*;
#(
  parameter int unsigned BITS_AB = DefaultBitsAb,
  parameter int unsigned DIM     = DefaultDim,
  parameter int unsigned CNT_W   = $clog2(2 * DIM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(DIM)-1:0]      wr_row,
  input  logic [DIM-1:0][BITS_AB-1:0] wr_data,
  input  logic                        wr_last,
  output logic                        wr_ready,
  input  logic                        transpose,
  input  logic                        en,
  output logic                        out_valid,
  output logic [DIM-1:0][BITS_AB-1:0] out_data,
  output logic                        tile_done,
  output logic                        busy
);

  localparam logic [CNT_W-1:0] LastT = CNT_W'(tile_beats(DIM) - 1);

  state_e                      state_q, state_d;
  logic [1:0]                  full_q, full_d;
  logic                        fill_q, fill_d;
  logic                        rd_q, rd_d;
  logic [CNT_W-1:0]            t_q, t_d;
  logic                        t_mode_q, t_mode_d;
  logic [DIM-1:0][BITS_AB-1:0] out_q, out_d;
  logic                        out_valid_q, out_valid_d;

  logic                        wr_fire;
  logic                        advance;
  logic [1:0]                  bank_we;
  logic [DIM-1:0][BITS_AB-1:0] bank_rd [2];

  assign wr_ready   = ~full_q[fill_q];
  assign wr_fire    = wr_en & wr_ready;
  assign bank_we[0] = wr_fire & ~fill_q;
  assign bank_we[1] = wr_fire & fill_q;
  assign advance    = (state_q == StStream) & en;
  assign tile_done  = advance & (t_q == LastT);
  assign busy       = (state_q == StStream) | full_q[0] | full_q[1];
  assign out_valid  = out_valid_q;
  assign out_data   = out_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    skew_bank #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .CNT_W   (CNT_W)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we[b]),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .t       (t_q),
      .t_mode  (t_mode_q),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    fill_d      = fill_q;
    rd_d        = rd_q;
    t_d         = t_q;
    t_mode_d    = t_mode_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (wr_fire && wr_last) begin
      full_d[fill_q] = 1'b1;
      fill_d         = ~fill_q;
    end

    unique case (state_q)
      StIdle: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        if (full_q[rd_q]) begin
          state_d  = StStream;
          t_d      = '0;
          t_mode_d = transpose;
        end
      end
      StStream: begin
        // en low stalls: counter and output register simply hold.
        if (en) begin
          out_d       = bank_rd[rd_q];
          out_valid_d = 1'b1;
          t_d         = t_q + CNT_W'(1);
          if (t_q == LastT) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
            t_d          = '0;
            // Chain straight into the other bank for a bubble-free handover.
            if (full_q[~rd_q]) begin
              t_mode_d = transpose;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      full_q      <= '0;
      fill_q      <= 1'b0;
      rd_q        <= 1'b0;
      t_q         <= '0;
      t_mode_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      fill_q      <= fill_d;
      rd_q        <= rd_d;
      t_q         <= t_d;
      t_mode_q    <= t_mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_skew_pingpong_buf.sv
// Randomised and directed bench for skew_pingpong_buf against a tile-queue reference model.
module tb_skew_pingpong_buf;

  localparam int unsigned Dim  = 4;
  localparam int unsigned Bits = 8;
  localparam int          Last = 2 * Dim - 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_en;
  logic [1:0]               wr_row;
  logic [Dim-1:0][Bits-1:0] wr_data;
  logic                     wr_last;
  logic                     wr_ready;
  logic                     transpose;
  logic                     en;
  logic                     out_valid;
  logic [Dim-1:0][Bits-1:0] out_data;
  logic                     tile_done;
  logic                     busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a FIFO of tile snapshots (a full bank is frozen until it streams).
  logic [127:0] bmem [2];
  logic [127:0] tiles [$];
  bit           m_active;
  int           m_beat;
  bit           m_mode;
  bit           m_fill;
  logic [31:0]  m_out;
  bit           m_valid;

  skew_pingpong_buf #(
    .BITS_AB (Bits),
    .DIM     (Dim),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .transpose (transpose),
    .en        (en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [127:0] tile, input int beat, input bit mode);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < Dim; j++) begin
      int k;
      k = beat - j;
      if (k >= 0 && k < Dim) begin
        r[j*8 +: 8] = mode ? tile[(k*4 + j)*8 +: 8] : tile[(j*4 + k)*8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic model_step();
    bit ready;
    if (!rst_n) begin
      tiles.delete();
      m_active = 1'b0;
      m_beat   = 0;
      m_mode   = 1'b0;
      m_fill   = 1'b0;
      m_out    = '0;
      m_valid  = 1'b0;
      return;
    end
    ready = tiles.size() < 2;
    if (m_active) begin
      if (en) begin
        m_out   = lanes(tiles[0], m_beat, m_mode);
        m_valid = 1'b1;
        if (m_beat == Last) begin
          void'(tiles.pop_front());
          if (tiles.size() > 0) begin
            m_beat = 0;
            m_mode = transpose;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_beat++;
        end
      end
    end else begin
      m_out   = '0;
      m_valid = 1'b0;
      if (tiles.size() > 0) begin
        m_active = 1'b1;
        m_beat   = 0;
        m_mode   = transpose;
      end
    end
    if (wr_en && ready) begin
      bmem[m_fill][int'(wr_row)*32 +: 32] = wr_data;
      if (wr_last) begin
        tiles.push_back(bmem[m_fill]);
        m_fill = ~m_fill;
      end
    end
  endtask

  initial begin
    bmem[0] = '0;
    bmem[1] = '0;
    m_active = 1'b0; m_beat = 0; m_mode = 1'b0; m_fill = 1'b0;
    m_out = '0; m_valid = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Every-cycle compare against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_data", out_data, m_out);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("wr_ready", 32'(wr_ready), 32'(tiles.size() < 2));
      chk("busy", 32'(busy), 32'(m_active || tiles.size() != 0));
      chk("tile_done", 32'(tile_done), 32'(m_active && en && m_beat == Last));
    end
  end

  task automatic load_tile(input int base);
    for (int r = 0; r < Dim; r++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_row  = 2'(r);
      wr_last = (r == Dim - 1);
      for (int c = 0; c < Dim; c++) wr_data[c] = 8'(base + 4*r + c);
    end
  endtask

  task automatic wr_idle();
    @(posedge clk); #1;
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk({tag, "_start_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // Assumes en stays high and no second tile is queued.
  task automatic watch_tile(input string tag, input logic [31:0] e0, input logic [31:0] e3,
                            input logic [31:0] e6);
    wait_valid(tag);
    for (int b = 0; b <= Last; b++) begin
      if (b == 0) chk({tag, "_beat0"}, out_data, e0);
      if (b == 3) chk({tag, "_beat3"}, out_data, e3);
      if (b == 5) chk({tag, "_done"}, 32'(tile_done), 32'd1);
      if (b == 6) chk({tag, "_beat6"}, out_data, e6);
      @(negedge clk);
    end
    chk({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; wr_last = 1'b0;
    transpose = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    transpose = 1'b0;
    load_tile(0);
    wr_idle();
    watch_tile("row", 32'h0, 32'h0C090603, 32'h0F000000);

    transpose = 1'b1;
    load_tile(0);
    wr_idle();
    watch_tile("col", 32'h0, 32'h0306090C, 32'h0F000000);

    // Reset mid-stream at beat 4.
    transpose = 1'b0;
    load_tile(0);
    wr_idle();
    wait_valid("rst");
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    load_tile(0);
    wr_idle();
    watch_tile("post_rst", 32'h0, 32'h0C090603, 32'h0F000000);

    // Both banks full: writes of 0x7F must be dropped.
    load_tile(0);
    load_tile(16);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_last = 1'b1; wr_row = 2'd0;
    for (int c = 0; c < Dim; c++) wr_data[c] = 8'h7F;
    @(negedge clk);
    chk("both_full_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1 wr_row = 2'd1;
    wr_idle();
    n = 0;
    while (!tile_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("first_done_seen", 32'(tile_done), 32'd1);
    chk("ready_at_done", 32'(wr_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_done", 32'(wr_ready), 32'd1);
    repeat (20) @(posedge clk);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      if (i == 1200) rst_n = 1'b0;
      if (i == 1202) rst_n = 1'b1;
      wr_en     = ($urandom % 3) == 0;
      wr_row    = 2'($urandom_range(0, 3));
      wr_last   = ($urandom % 6) == 0;
      transpose = $urandom % 2;
      en        = ($urandom % 8) != 0;
      for (int c = 0; c < Dim; c++) begin
        wr_data[c] = (($urandom % 5) == 0) ? 8'h7F : 8'($urandom);
      end
    end

    @(posedge clk); #1;
    wr_en = 1'b0; wr_last = 1'b0; en = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
